// File: rtl/mem_block_mover.sv
// Block copy / block fill engine for the data bsram, one word per clock.
// Owns both bsram ports while busy; copy reads run one cycle ahead of their writes.
//
// state | meaning
// IDLE  | waiting for start, request fields latched on start
// COPY  | issuing reads src+k, writing the word read on the previous cycle
// DRAIN | last copy write, no read issued
// FILL  | writing fill_value to dst+k
// FIN   | one-cycle done pulse
module mem_block_mover #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] src,
    input  logic [WIDTH-1:0] dst,
    input  logic [WIDTH:0]   len,
    input  logic [15:0]      fill_value,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] mem_dout_addr,
    input  logic [15:0]      mem_dout,
    output logic             we,
    output logic [WIDTH-1:0] mem_din_addr,
    output logic [15:0]      mem_din
);

    typedef enum logic [2:0] {IDLE, COPY, DRAIN, FILL, FIN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH:0]   cnt, cnt_nxt;
    logic [WIDTH-1:0] rd_addr, rd_addr_nxt;
    logic [WIDTH-1:0] wr_addr, wr_addr_nxt;
    logic [WIDTH-1:0] wr_ptr, wr_ptr_nxt;
    logic [15:0]      fill_q, fill_nxt;
    logic             we_q, we_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic             pass_q, pass_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            rd_addr <= '0;
            wr_addr <= '0;
            wr_ptr  <= '0;
            fill_q  <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rd_addr <= rd_addr_nxt;
            wr_addr <= wr_addr_nxt;
            wr_ptr  <= wr_ptr_nxt;
            fill_q  <= fill_nxt;
            we_q    <= we_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
            pass_q  <= pass_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        rd_addr_nxt = rd_addr;
        wr_addr_nxt = wr_addr;
        wr_ptr_nxt  = wr_ptr;
        fill_nxt    = fill_q;
        we_nxt      = 1'b0;
        busy_nxt    = busy_q;
        done_nxt    = 1'b0;
        pass_nxt    = pass_q;
        case (state)
            IDLE: begin
                if (start) begin
                    fill_nxt = fill_value;
                    if (len == '0) begin
                        state_nxt = FIN;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt  = len - 1'b1;
                        busy_nxt = 1'b1;
                        if (mode) begin
                            state_nxt   = FILL;
                            we_nxt      = 1'b1;
                            wr_addr_nxt = dst;
                            wr_ptr_nxt  = dst + 1'b1;
                            pass_nxt    = 1'b0;
                        end else begin
                            state_nxt   = COPY;
                            rd_addr_nxt = src;
                            wr_ptr_nxt  = dst;
                        end
                    end
                end
            end
            COPY: begin
                we_nxt      = 1'b1;
                wr_addr_nxt = wr_ptr;
                wr_ptr_nxt  = wr_ptr + 1'b1;
                pass_nxt    = 1'b1;
                if (cnt == '0) begin
                    state_nxt = DRAIN;
                end else begin
                    rd_addr_nxt = rd_addr + 1'b1;
                    cnt_nxt     = cnt - 1'b1;
                end
            end
            DRAIN: begin
                state_nxt = FIN;
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
                pass_nxt  = 1'b0;
            end
            FILL: begin
                if (cnt == '0) begin
                    state_nxt = FIN;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else begin
                    we_nxt      = 1'b1;
                    wr_addr_nxt = wr_ptr;
                    wr_ptr_nxt  = wr_ptr + 1'b1;
                    cnt_nxt     = cnt - 1'b1;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign we            = we_q;
    assign mem_dout_addr = rd_addr;
    assign mem_din_addr  = wr_addr;
    // bsram read data is already registered and arrives in the write cycle, so copy data
    // is forwarded through a registered select rather than re-registered (which would add a cycle).
    assign mem_din       = pass_q ? mem_dout : fill_q;

endmodule

// File: tb/tb_mem_block_mover.sv
// Bench for mem_block_mover: bsram model, per-cycle behavioural reference,
// directed scenarios with literal expectations and randomized transfers.
module tb_mem_block_mover;
    localparam int W = 10;
    localparam int N = 1 << W;

    logic          clk = 1'b0;
    logic          reset, start, mode;
    logic [W-1:0]  src, dst;
    logic [W:0]    len;
    logic [15:0]   fill_value;
    logic          busy, done, we;
    logic [W-1:0]  mem_dout_addr, mem_din_addr;
    logic [15:0]   mem_dout, mem_din;

    logic          tb_we;
    logic [W-1:0]  tb_addr;
    logic [15:0]   tb_data;
    logic [15:0]   mem     [0:N-1];
    logic [15:0]   exp_mem [0:N-1];

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    always #5 clk = ~clk;

    mem_block_mover #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .src(src), .dst(dst), .len(len), .fill_value(fill_value),
        .busy(busy), .done(done),
        .mem_dout_addr(mem_dout_addr), .mem_dout(mem_dout),
        .we(we), .mem_din_addr(mem_din_addr), .mem_din(mem_din)
    );

    always @(posedge clk) begin
        if (we) mem[mem_din_addr] <= mem_din;
        if (tb_we) mem[tb_addr] <= tb_data;
        mem_dout <= mem[mem_dout_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: transfer seen as a function of cycle offset d from the accepted start.
    bit          act_m = 1'b0;
    int          xt = 0, xl = 0, done_d = 0, xsrc = 0, xdst = 0, last_rd = 0;
    bit          xmode = 1'b0;
    logic [15:0] xfill = '0;
    logic [15:0] rd_prev = '0;

    always @(negedge clk) begin
        int d, e_waddr, e_raddr;
        bit e_busy, e_we, e_done, e_rd;
        logic [15:0] e_wdata;
        if (reset) begin
            act_m   = 1'b0;
            last_rd = 0;
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_we", we, 0);
            chk("rst_rd_addr", mem_dout_addr, 0);
            chk("rst_wr_addr", mem_din_addr, 0);
            chk("rst_din", mem_din, 0);
            if (tb_we) exp_mem[tb_addr] = tb_data;
        end else begin
            e_busy = 0; e_we = 0; e_done = 0; e_rd = 0;
            e_waddr = 0; e_raddr = 0; e_wdata = '0;
            d = cyc - xt;
            if (act_m) begin
                if (xl == 0) begin
                    e_busy = 0;
                end else if (xmode) begin
                    e_we    = (d >= 1 && d <= xl);
                    e_busy  = e_we;
                    e_waddr = (xdst + d - 1) % N;
                    e_wdata = xfill;
                end else begin
                    e_rd    = (d >= 1 && d <= xl);
                    e_raddr = (xsrc + d - 1) % N;
                    e_we    = (d >= 2 && d <= xl + 1);
                    e_waddr = (xdst + d + N - 2) % N;
                    e_wdata = rd_prev;
                    e_busy  = (d >= 1 && d <= xl + 1);
                end
                e_done = (d == done_d);
            end
            if (e_rd) last_rd = e_raddr;
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("we", we, e_we);
            chk("rd_addr", mem_dout_addr, last_rd);
            if (e_we) begin
                chk("wr_addr", mem_din_addr, e_waddr);
                chk("wr_data", mem_din, e_wdata);
            end
            if (e_rd) rd_prev = exp_mem[e_raddr];
            if (e_we) exp_mem[e_waddr] = e_wdata;
            if (tb_we) exp_mem[tb_addr] = tb_data;
            if (start && (!act_m || d > done_d)) begin
                act_m  = 1'b1;
                xt     = cyc;
                xl     = int'(len);
                xmode  = mode;
                xsrc   = int'(src);
                xdst   = int'(dst);
                xfill  = fill_value;
                done_d = (xl == 0) ? 1 : (mode ? xl + 1 : xl + 2);
            end
        end
    end

    task automatic poke(input int a, input logic [15:0] v);
        tb_we   = 1'b1;
        tb_addr = a[W-1:0];
        tb_data = v;
        @(posedge clk); #1;
        tb_we   = 1'b0;
    endtask

    task automatic mem_check(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < N; i++)
            if (mem[i] !== exp_mem[i]) bad++;
        chk(name, bad, 0);
    endtask

    task automatic xfer(input logic m, input int s, input int d, input int l,
                        input logic [15:0] f, input int extra,
                        output int dl, output int fw, output int nw);
        start      = 1'b1;
        mode       = m;
        src        = s[W-1:0];
        dst        = d[W-1:0];
        len        = l[W:0];
        fill_value = f;
        dl = -1; fw = -1; nw = 0;
        for (int i = 1; i <= l + 10 && dl < 0; i++) begin
            @(posedge clk); #1;
            start = (i == extra);
            @(negedge clk);
            if (we === 1'b1) begin
                nw++;
                if (fw < 0) fw = i;
            end
            if (done === 1'b1) dl = i;
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int dl, fw, nw, s, d, l, ex, m;
        reset = 1'b1; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0;
        fill_value = '0; tb_we = 1'b0; tb_addr = '0; tb_data = '0;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) poke(i, 16'($urandom));
        chk("reset_busy", busy, 0);
        chk("reset_we", we, 0);
        chk("reset_din", mem_din, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        xfer(1'b1, 'h100, 'h100, 4, 16'hBEEF, 0, dl, fw, nw);
        chk("fill_done_lat", dl, 5);
        chk("fill_first_we", fw, 1);
        chk("fill_nwr", nw, 4);
        for (int k = 0; k < 4; k++) chk("fill_word", mem['h100 + k], 16'hBEEF);

        poke('h10, 16'h1111); poke('h11, 16'h2222); poke('h12, 16'h3333);
        xfer(1'b0, 'h10, 'h200, 3, 16'h0, 0, dl, fw, nw);
        chk("copy_done_lat", dl, 5);
        chk("copy_first_we", fw, 2);
        chk("copy_nwr", nw, 3);
        chk("copy_w0", mem['h200], 16'h1111);
        chk("copy_w1", mem['h201], 16'h2222);
        chk("copy_w2", mem['h202], 16'h3333);
        mem_check("copy_mem");

        xfer(1'b1, 0, 'h50, 0, 16'h5555, 0, dl, fw, nw);
        chk("zero_done_lat", dl, 1);
        chk("zero_nwr", nw, 0);
        mem_check("zero_mem");

        xfer(1'b1, 0, N - 2, 4, 16'h00AA, 0, dl, fw, nw);
        chk("wrap_done_lat", dl, 5);
        chk("wrap_a", mem[N-2], 16'h00AA);
        chk("wrap_b", mem[N-1], 16'h00AA);
        chk("wrap_c", mem[0], 16'h00AA);
        chk("wrap_d", mem[1], 16'h00AA);

        xfer(1'b0, 'h40, 'h80, 8, 16'h0, 3, dl, fw, nw);
        chk("busy_start_nwr", nw, 8);
        chk("busy_start_done_lat", dl, 10);
        mem_check("busy_start_mem");

        for (int k = 0; k < 8; k++) begin
            poke('h300 + k, 16'(16'h5000 + k));
            poke('h340 + k, 16'h0000);
        end
        start = 1'b1; mode = 1'b0; src = 'h300; dst = 'h340; len = 8;
        repeat (4) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("pre_reset_we", we, 1);
        reset = 1'b1;
        #1;
        chk("abort_we", we, 0);
        chk("abort_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_w0", mem['h340], 16'h5000);
        chk("abort_w1", mem['h341], 16'h5001);
        chk("abort_w2", mem['h342], 16'h0000);
        chk("abort_w7", mem['h347], 16'h0000);
        mem_check("abort_mem");

        xfer(1'b1, 0, 'h360, 2, 16'hCAFE, 0, dl, fw, nw);
        chk("post_reset_done_lat", dl, 3);
        chk("post_reset_nwr", nw, 2);
        chk("post_reset_word", mem['h361], 16'hCAFE);

        for (int k = 0; k < 4; k++) poke('h20 + k, 16'(k + 1));
        xfer(1'b0, 'h21, 'h20, 3, 16'h0, 0, dl, fw, nw);
        chk("ovl_0", mem['h20], 16'd2);
        chk("ovl_1", mem['h21], 16'd3);
        chk("ovl_2", mem['h22], 16'd4);
        chk("ovl_3", mem['h23], 16'd4);

        xfer(1'b0, 5, 5, N, 16'h0, 0, dl, fw, nw);
        chk("full_copy_done_lat", dl, N + 2);
        chk("full_copy_nwr", nw, N);
        mem_check("full_copy_mem");

        xfer(1'b1, 0, 7, N, 16'h1234, 0, dl, fw, nw);
        chk("full_fill_done_lat", dl, N + 1);
        chk("full_fill_nwr", nw, N);
        chk("full_fill_word", mem[6], 16'h1234);
        mem_check("full_fill_mem");

        for (int k = 0; k < N; k += 3) poke(k, 16'($urandom));
        for (int r = 0; r < 40; r++) begin
            m = int'($urandom_range(0, 1));
            l = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
            s = int'($urandom_range(0, N - 1));
            d = int'($urandom_range(0, N - 1));
            if (m == 0 && l > 0 && ((d - s + N) % N) != 0 && ((d - s + N) % N) < l)
                d = (s + N - int'($urandom_range(0, 8))) % N;
            ex = int'($urandom_range(0, l + 2));
            xfer(m[0], s, d, l, 16'($urandom), ex, dl, fw, nw);
            chk("rand_done_lat", dl, (l == 0) ? 1 : ((m == 1) ? l + 1 : l + 2));
            chk("rand_nwr", nw, l);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
        end
        mem_check("rand_mem");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/mem_block_mover.md
Name: mem_block_mover

Overview:
- Block-copy / block-fill DMA engine that sits directly upstream of the data memory (bsram).
- Drives both the sync read port and the write port of bsram. Moves `len` words from `src` to `dst`, or fills `len` words at `dst` with a constant, at 1 word/clk.
- Used for fast clears and sprite/rect table copies on behalf of the CPU. The CPU side only sees start/busy/done.

Parameters:
- WIDTH, `DATA_ADDR_WIDTH, word-address width of the data memory.

Ports:
- clk  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request; sampled only in IDLE
- mode  in  1  0 = copy, 1 = fill; sampled with start
- src  in  WIDTH  copy source base address; sampled with start
- dst  in  WIDTH  destination base address; sampled with start
- len  in  WIDTH+1  word count, 0..2^WIDTH; sampled with start
- fill_value  in  16  fill word; sampled with start
- busy  out  1  high while a transfer is in progress
- done  out  1  one-cycle pulse at transfer completion
- mem_dout_addr  out  WIDTH  bsram read address
- mem_dout  in  16  bsram read data, valid 1 clk after address
- we  out  1  bsram write enable
- mem_din_addr  out  WIDTH  bsram write address
- mem_din  out  16  bsram write data

Behaviour:
- Reset (async, immediate) sets busy=0, done=0, we=0, mem_dout_addr=0, mem_din_addr=0, mem_din=0, and state=IDLE.
- Reset mid-transfer aborts the transfer: we drops in the same instant, there is no done pulse, and words already written stay written.
- All outputs are registered.
- FSM states:
  - IDLE: if start=1, latch mode/src/dst/len/fill_value. If len=0, go to FIN. Otherwise go to COPY or FILL.
  - COPY: read pointer rp=src+k is issued on mem_dout_addr on cycles t+1..t+len (t = the start cycle). Each read is written 1 clk later: we=1, mem_din_addr=dst+k, mem_din=mem_dout on cycles t+2..t+1+len. After the last read issue, go to DRAIN for one cycle (the last write). Then go to FIN.
  - FILL: we=1, mem_din_addr=dst+k, mem_din=fill_value on cycles t+1..t+len. No reads are issued. After the last write, go to FIN.
  - FIN: done=1 for exactly one cycle, busy=0. Then go to IDLE.
- busy is high from t+1 through the cycle of the last write. For len=0 it never rises; done pulses at t+1.
- done pulse timing:
  - copy: cycle t+2+len
  - fill: cycle t+1+len
- start while busy or in FIN is ignored; no queuing.
- Addresses increment modulo 2^WIDTH, so src+k and dst+k wrap to 0 past the top.
- len=2^WIDTH covers the whole memory. The internal down-counter is WIDTH+1 bits.
- Outside COPY/DRAIN/FILL: we=0 and mem_dout_addr holds its last value (0 after reset).
- Overlap: copies with dst in (src, src+len) give undefined data, and software must not issue them.
  - dst <= src is valid, because forward order reads each word before it is overwritten.
  - dst == src is valid and rewrites identical data.
- No stall input: the block owns both bsram ports while busy. External arbitration muxes the ports on busy.

Test Plan:
- Fill: mode=1, dst=0x0100, len=4, fill_value=0xBEEF -> we high for 4 cycles. Addresses 0x0100..0x0103 are each written 0xBEEF. done pulses at t+5. busy is high t+1..t+4.
- Copy: preload 0x0010..0x0012 = 0x1111, 0x2222, 0x3333. Start with mode=0, src=0x0010, dst=0x0200, len=3 -> 0x0200..0x0202 match the preload. First write at t+2. done at t+5. No write to any other address.
- Zero length: len=0 -> done at t+1, busy and we never high, memory unchanged.
- Wrap: fill with dst=2^WIDTH-2, len=4, fill_value=0x00AA -> addresses 2^WIDTH-2, 2^WIDTH-1, 0, 1 are written. done at t+5.
- Busy and reset:
  - Pulse start again during a copy of len=8 -> ignored, exactly 8 writes.
  - In a new copy of len=8, assert reset at t+4 -> we=0 and busy=0 immediately, no done pulse, only the first 2 destination words are written.
  - After reset is released, a new start is accepted normally.
- Backward-overlap copy: preload 0x0020..0x0023 = 1, 2, 3, 4. Copy src=0x0021, dst=0x0020, len=3 -> 0x0020..0x0023 = 2, 3, 4, 4.
